// File: rtl/xfpga_pkg.sv
// xfpga_pkg: shared constants and types for the DSP XINTF write endpoint.
//   ADDR_COMMIT      keyed commit address (staging -> outputs)
//   ADDR_STG1..4     staging register addresses
//   COMMIT_KEY       data word that makes a write to ADDR_COMMIT take effect
//   state_t          strobe qualification FSM states
package xfpga_pkg;

  localparam logic [19:0] ADDR_COMMIT = 20'h0FC00;
  localparam logic [19:0] ADDR_STG1   = 20'h0FC01;
  localparam logic [19:0] ADDR_STG2   = 20'h0FC02;
  localparam logic [19:0] ADDR_STG3   = 20'h0FC03;
  localparam logic [19:0] ADDR_STG4   = 20'h0FC04;

  localparam logic [15:0] COMMIT_KEY  = 16'hA55A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/xfpga_sync.sv
// xfpga_sync: two-flop synchronizer of configurable width.
//   clk      destination clock
//   rst      asynchronous active-high reset; both stages load RST_VAL
//   d        asynchronous input
//   q        synchronized output (second stage)
module xfpga_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s_p0;
  logic [W-1:0] s_p1;

  // stage 0 -> stage 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_p0 <= RST_VAL;
      s_p1 <= RST_VAL;
    end else begin
      s_p0 <= d;
      s_p1 <= s_p0;
    end
  end

  assign q = s_p1;

endmodule

// File: rtl/xfpga_read.sv
// xfpga_read: write-side endpoint of the DSP XINTF bus.
// DSP write strobes are synchronized, qualified by a minimum low width and
// decoded into four staging registers; a keyed commit copies all staging
// registers to the outputs in one cycle for tear-free parameter updates.
//   clk             system clock
//   global_rst      asynchronous active-high reset
//   wen             DSP write enable, active low, asynchronous
//   xadd, xdata     DSP address / data (input only)
//   dsp2fpga1..4    committed parameter registers
//   wr_stb          one-cycle pulse per staging register written (bit0 = reg 1)
//   upd             one-cycle pulse on an accepted commit
//   wdog_fault      sticky watchdog fault (constant 0 unless XFPGA_WDOG_EN)
// Optional feature macro: XFPGA_WDOG_EN enables the commit watchdog, which
// forces the outputs to zero when no commit arrives within WDOG_CYC cycles.
module xfpga_read
  import xfpga_pkg::*;
#(
  parameter int MIN_LOW  = 2,
  parameter int WDOG_CYC = 100000
) (
  input  logic        clk,
  input  logic        global_rst,
  input  logic        wen,
  input  logic [19:0] xadd,
  input  logic [15:0] xdata,
  output logic [15:0] dsp2fpga1,
  output logic [15:0] dsp2fpga2,
  output logic [15:0] dsp2fpga3,
  output logic [15:0] dsp2fpga4,
  output logic [3:0]  wr_stb,
  output logic        upd,
  output logic        wdog_fault
);

  localparam int LW = $clog2(MIN_LOW + 1);

  logic          wen_s;
  logic [35:0]   bus_s;
  logic [19:0]   xadd_s;
  logic [15:0]   xdata_s;

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] low_cnt;

  logic [19:0]   addr_lat;
  logic [15:0]   data_lat;
  logic [3:0]    stg_hit;
  logic          commit;

  logic [15:0]   stage [4];
  logic [15:0]   out_q [4];

  // Address/data share the wen pipeline depth so that the values seen with
  // the last synchronized-low wen are the ones sampled at the last low edge.
  xfpga_sync #(.W(1), .RST_VAL(1'b1)) u_sync_wen (
    .clk (clk),
    .rst (global_rst),
    .d   (wen),
    .q   (wen_s)
  );

  xfpga_sync #(.W(36), .RST_VAL(36'd0)) u_sync_bus (
    .clk (clk),
    .rst (global_rst),
    .d   ({xadd, xdata}),
    .q   (bus_s)
  );

  assign xadd_s  = bus_s[35:16];
  assign xdata_s = bus_s[15:0];

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!wen_s) state_nxt = ACTIVE;
      // Strobes shorter than MIN_LOW are treated as glitches and dropped.
      ACTIVE:  if (wen_s) state_nxt = (low_cnt >= LW'(MIN_LOW)) ? CAPTURE : IDLE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      low_cnt <= '0;
    end else if (state == IDLE && !wen_s) begin
      low_cnt <= LW'(1);
    end else if (state == ACTIVE && !wen_s && low_cnt < LW'(MIN_LOW)) begin
      low_cnt <= low_cnt + LW'(1);
    end
  end

  // Latches track the bus for as long as wen stays low; the last load wins.
  always_ff @(posedge clk) begin
    if (!wen_s && (state == IDLE || state == ACTIVE)) begin
      addr_lat <= xadd_s;
      data_lat <= xdata_s;
    end
  end

  always_comb begin
    stg_hit = 4'b0000;
    commit  = 1'b0;
    if (state == CAPTURE) begin
      case (addr_lat)
        ADDR_STG1:   stg_hit = 4'b0001;
        ADDR_STG2:   stg_hit = 4'b0010;
        ADDR_STG3:   stg_hit = 4'b0100;
        ADDR_STG4:   stg_hit = 4'b1000;
        ADDR_COMMIT: commit  = (data_lat == COMMIT_KEY);
        default:     ;
      endcase
    end
  end

  // decode -> staging / strobes
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      for (int i = 0; i < 4; i++) stage[i] <= '0;
      wr_stb <= 4'b0000;
      upd    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (stg_hit[i]) stage[i] <= data_lat;
      end
      wr_stb <= stg_hit;
      upd    <= commit;
    end
  end

`ifdef XFPGA_WDOG_EN
  localparam int CW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

  logic [CW-1:0] wdog_cnt;
  logic          wdog_q;
  logic          expire;

  assign expire = (wdog_cnt == CW'(WDOG_CYC - 1));

  // The counter parks at its terminal value so the fault keeps the outputs
  // cleared until a commit restarts it; a commit always beats an expiry.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      wdog_cnt <= '0;
      wdog_q   <= 1'b0;
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else begin
      if (commit)       wdog_cnt <= '0;
      else if (!expire) wdog_cnt <= wdog_cnt + CW'(1);

      if (commit) begin
        wdog_q <= 1'b0;
        for (int i = 0; i < 4; i++) out_q[i] <= stage[i];
      end else if (expire || wdog_q) begin
        wdog_q <= 1'b1;
        for (int i = 0; i < 4; i++) out_q[i] <= '0;
      end
    end
  end

  assign wdog_fault = wdog_q;
`else
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < 4; i++) out_q[i] <= stage[i];
    end
  end

  assign wdog_fault = 1'b0;
`endif

  assign dsp2fpga1 = out_q[0];
  assign dsp2fpga2 = out_q[1];
  assign dsp2fpga3 = out_q[2];
  assign dsp2fpga4 = out_q[3];

endmodule

// File: doc/xfpga_read.md
# xfpga_read

Write-side endpoint of the DSP XINTF bus: captures DSP write cycles (active-low `wen`, 20-bit `xadd`, 16-bit `xdata`) into four staging registers. The staged values are transferred to the FPGA-side outputs `dsp2fpga1..4` in a single cycle when the DSP writes a keyed commit. This gives the control logic (PWM/current loop) tear-free parameter updates. The block is the counterpart of the FPGA-to-DSP read-back path on the same address window.

## Interface
Parameters:
- `MIN_LOW`, 2: minimum number of synchronized `wen` low cycles for a strobe to be accepted.
- `WDOG_CYC`, 100000: watchdog timeout in `clk` cycles. Used only with `XFPGA_WDOG_EN`.

Ports:
- `clk`  in  1  system clock.
- `global_rst`  in  1  asynchronous, active-high reset.
- `wen`  in  1  DSP write enable, active low, asynchronous to `clk`.
- `xadd`  in  20  DSP address.
- `xdata`  in  16  DSP data. Input only; this block never drives the bus.
- `dsp2fpga1..4`  out  16 each  committed parameter registers.
- `wr_stb`  out  4  one-cycle pulse per staging register written (bit0 = register 1).
- `upd`  out  1  one-cycle pulse when a commit transfers staging to outputs.
- `wdog_fault`  out  1  sticky watchdog fault. Tied to 0 without `XFPGA_WDOG_EN`.

## Operation
- Synchronization:
  - `wen`, `xadd` and `xdata` pass through an identical 2-flop pipeline.
  - The `wen` flops reset to 1. The `xadd`/`xdata` flops reset to 0.
  - `wen_s` denotes the second-stage `wen`.
- FSM states: IDLE, ACTIVE, CAPTURE.
  - IDLE -> ACTIVE when `wen_s`=0. The low counter `low_cnt` clears to 1.
  - While in ACTIVE with `wen_s`=0:
    - `low_cnt` increments, saturating at `MIN_LOW`.
    - `addr_lat`/`data_lat` load the pipelined `xadd`/`xdata` every cycle.
  - ACTIVE with `wen_s`=1:
    - goes to CAPTURE if `low_cnt`>=`MIN_LOW`;
    - otherwise goes to IDLE (glitch, discarded, no side effect).
  - CAPTURE -> IDLE unconditionally after one cycle, performing the decode below.
- Decode in CAPTURE, on `addr_lat`:
  - 20'h0FC01..20'h0FC04: `stage[n]` <= `data_lat`; `wr_stb[n]` pulses.
  - 20'h0FC00 with `data_lat`==16'hA55A: all four `dsp2fpga*` <= `stage*` in the same cycle; `upd` pulses.
  - 20'h0FC00 with any other data: ignored.
  - Any other address: ignored, no strobe.
- Staging registers are not visible on the outputs until committed. Writing staging does not alter `dsp2fpga*`.
- Reset values: `dsp2fpga*`=0, `stage*`=0, `wr_stb`=0, `upd`=0, `wdog_fault`=0, FSM=IDLE, `low_cnt`=0.
- Reset mid-write: the cycle in progress is lost. If `wen` is still low after release, the FSM enters ACTIVE once `wen_s`=0 and accepts the write only if `MIN_LOW` is met afresh.

## Timing
- Define E0 as the first `clk` edge that samples the `wen` pin high after a valid strobe. Then:
  - E1: `wen_s`=1.
  - E2: the FSM enters CAPTURE.
  - E3: `stage`/`dsp2fpga` update, and `wr_stb`/`upd` are high for the cycle following E3.
- Write-to-output latency is therefore 4 `clk` edges from the `wen` rising edge.
- Data/address used are those sampled at the last edge that saw `wen` low. The DSP must hold `xadd`/`xdata` stable across that edge, with normal setup/hold to `clk`.
- Minimum accepted strobe: `MIN_LOW` synchronized low cycles. Minimum spacing between writes: `wen` high for ≥2 cycles, so that the FSM returns to IDLE.
- Back-to-back writes to the same staging register: the last one wins. Each write produces its own `wr_stb` pulse.

## Configuration
- `XFPGA_WDOG_EN` defined:
  - A counter increments every cycle and reloads to 0 on each accepted commit.
  - When it reaches `WDOG_CYC-1`, `wdog_fault` sets (sticky) and all `dsp2fpga*` are forced to 0 on the next edge.
  - Later staging writes do not change the outputs.
  - The next accepted commit clears `wdog_fault` and loads the outputs normally.
  - If a commit and expiry occur in the same cycle, the commit wins.
- `XFPGA_WDOG_EN` undefined: no counter is built, and `wdog_fault` is a constant 0.

## Structure
- Package `xfpga_pkg`:
  - address constants (`ADDR_COMMIT` 20'h0FC00, `ADDR_STG1..4`);
  - `COMMIT_KEY` 16'hA55A;
  - FSM state enum.
- Sub-module `xfpga_sync`: parameterized-width 2-flop synchronizer with a reset value parameter. It is instantiated for `wen` (reset 1) and for {`xadd`,`xdata`} (reset 0).

## Test plan
- Write 16'h1234 to 20'h0FC02 with a 5-cycle `wen` low strobe -> `wr_stb`=4'b0010 for one cycle 4 edges after `wen` rises; `dsp2fpga2` remains 0.
- Stage 0x1111/0x2222/0x3333/0x4444 to registers 1..4, then write 16'hA55A to 20'h0FC00 -> all four outputs change in the same cycle; `upd` pulses once.
- Commit with 16'h0000, and a 1-cycle `wen` glitch to 20'h0FC01 (`MIN_LOW`=2) -> no output change, no `wr_stb`, no `upd`.
- Assert `global_rst` while `wen` is low mid-strobe -> all outputs 0 immediately. After release, the held-low strobe is accepted only after `MIN_LOW` fresh cycles.
- With `XFPGA_WDOG_EN` and `WDOG_CYC`=16:
  - no commit for 16 cycles -> `wdog_fault`=1 and outputs 0;
  - staging write -> outputs stay 0;
  - valid commit -> fault clears and staged values appear.
- Write to 20'h0FD05 (read-back window) -> no strobe, no state change.
